// File: rtl/exins_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : exins_pkg                                              |
// | Description : Shared types and constants for the external-instruction|
// |               responder: FSM state encoding, default out-of-range   |
// |               word, external-space base and a range-check helper.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package exins_pkg;

   // Responder FSM states, explicit 2-bit encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } exins_state_e;

   // Word handed back for any address outside the local store
   localparam logic [31:0] c_OOR_DATA = 32'h0000_0000;

   // External space starts right after the fetch stage's 64 KiB memory;
   // request addresses arrive already relative to this base
   localparam logic [31:0] c_EXT_BASE = 32'h0001_0000;

   // True when every address bit above the word index is zero
   function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
      return (addr >> (aw + 2)) == 32'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/exins_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : exins_if                                               |
// | Description : Fetch-stage external-instruction port. The fetch stage |
// |               is the master (request + address), the responder is   |
// |               the slave (valid strobe + instruction word).          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface exins_if;

   logic        exIns_ren;
   logic [31:0] exIns_addr;
   logic        exIns_valid;
   logic [31:0] exIns_in;

   modport master (
      output exIns_ren,
      output exIns_addr,
      input  exIns_valid,
      input  exIns_in
   );

   modport slave (
      input  exIns_ren,
      input  exIns_addr,
      output exIns_valid,
      output exIns_in
   );

endinterface
`default_nettype wire

// File: rtl/exins_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : exins_ram                                              |
// | Description : 2^AW x 32 instruction store. One synchronous read port |
// |               and one write port; a same-cycle read and write to the|
// |               same index returns the old word (read-before-write).  |
// |               The array itself is never reset; only the read-data   |
// |               register is, so the response word starts at zero.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module exins_ram
   import exins_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data
);

   localparam int c_DEPTH = 1 << AW;

   logic [31:0] r_mem [0:c_DEPTH-1];
   logic [31:0] r_rd_data;

   // Write port: host-side loads land on any cycle
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_idx] <= wr_data;
      end
   end

   // Read port: samples the array before this edge's write takes effect
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rd_data <= '0;
      end else if (rd_en) begin
         r_rd_data <= r_mem[rd_idx];
      end
   end

   assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/exins_server.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : exins_server                                           |
// | Description : External instruction responder. Latches a fetch       |
// |               request, waits LATENCY cycles (restarting on address  |
// |               change, aborting when the request drops), then returns|
// |               the stored word with a one-cycle valid strobe.        |
// |               Out-of-range addresses return OOR_DATA.               |
// |               Optional: define EXINS_ERR_EN to add the sticky       |
// |               err_oor / err_addr out-of-range capture ports.        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module exins_server
   import exins_pkg::*;
#(
   parameter int          AW       = 10,
   parameter int          LATENCY  = 2,
   parameter logic [31:0] OOR_DATA = c_OOR_DATA
) (
   input  logic          clk,
   input  logic          nrst,
   exins_if.slave        fetch,
   output logic          busy,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_data
`ifdef EXINS_ERR_EN
   ,
   output logic          err_oor,
   output logic [31:0]   err_addr
`endif
);

   // Counter only needs to hold LATENCY-1 (the number of WAIT cycles)
   localparam int              c_CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [c_CW-1:0] c_RELOAD = c_CW'(LATENCY - 1);
   localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

   exins_state_e    r_state;
   exins_state_e    w_next_state;
   logic [c_CW-1:0] r_cnt;
   logic [c_CW-1:0] w_cnt_next;
   logic [31:0]     r_addr;
   logic [31:0]     w_addr_next;
   logic            r_valid;
   logic            r_oor;
   logic            w_rd_en;
   logic [31:0]     w_sel_addr;
   logic            w_sel_oor;
   logic [AW-1:0]   w_rd_idx;
   logic [31:0]     w_ram_data;

   // Next-state, counter and store-read decisions
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_addr_next  = r_addr;
      w_rd_en      = 1'b0;
      w_sel_addr   = r_addr;

      case (r_state)
         IDLE: begin
            // With LATENCY=1 the store is read on the very sampling edge,
            // so the live address has to feed the read port here
            w_sel_addr = fetch.exIns_addr;
            if (fetch.exIns_ren) begin
               w_addr_next = fetch.exIns_addr;
               w_cnt_next  = c_RELOAD;
               if (LATENCY == 1) begin
                  w_next_state = RESP;
                  w_rd_en      = 1'b1;
               end else begin
                  w_next_state = WAIT;
               end
            end
         end

         WAIT: begin
            if (!fetch.exIns_ren) begin
               w_next_state = IDLE;
            end else if (fetch.exIns_addr != r_addr) begin
               // Fetch stage redirected: start over for the new address
               w_addr_next = fetch.exIns_addr;
               w_cnt_next  = c_RELOAD;
            end else if (r_cnt == c_ONE) begin
               w_next_state = RESP;
               w_rd_en      = 1'b1;
            end else begin
               w_cnt_next = r_cnt - c_ONE;
            end
         end

         RESP: begin
            w_next_state = IDLE;
         end

         default: begin
            w_next_state = IDLE;
         end
      endcase

      w_sel_oor = !addr_in_range(w_sel_addr, AW);
   end

   assign w_rd_idx = w_sel_addr[AW+1:2];

   // FSM, latched address and response-strobe registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_valid <= 1'b0;
         r_oor   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
         r_addr  <= w_addr_next;
         r_valid <= (w_next_state == RESP);
         if (w_rd_en) begin
            r_oor <= w_sel_oor;
         end
      end
   end

   exins_ram #(
      .AW (AW)
   ) u_ram (
      .clk     (clk),
      .nrst    (nrst),
      .rd_en   (w_rd_en),
      .rd_idx  (w_rd_idx),
      .rd_data (w_ram_data),
      .wr_en   (ld_we),
      .wr_idx  (ld_addr),
      .wr_data (ld_data)
   );

   // Both mux inputs are flops that only change on the edge entering RESP
   assign fetch.exIns_valid = r_valid;
   assign fetch.exIns_in    = r_oor ? OOR_DATA : w_ram_data;
   assign busy              = (r_state != IDLE);

`ifdef EXINS_ERR_EN
   logic        r_err_oor;
   logic [31:0] r_err_addr;

   // Capture only the first out-of-range request served; sticky until reset
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_err_oor  <= 1'b0;
         r_err_addr <= '0;
      end else if ((r_state == RESP) && r_oor && !r_err_oor) begin
         r_err_oor  <= 1'b1;
         r_err_addr <= r_addr;
      end
   end

   assign err_oor  = r_err_oor;
   assign err_addr = r_err_addr;
`endif

endmodule
`default_nettype wire

// File: doc/exins_server.md
# exins_server

External instruction responder serving the fetch stage's external-instruction port. When the fetch stage raises `exIns_ren` with a word address on `exIns_addr`, this block looks the word up in a local instruction store and returns it on `exIns_in` with a one-cycle `exIns_valid` strobe after a fixed, parameterized latency. A host-side load port fills the store at any time, including while fetches are in flight.

## Interface
- `AW`, 10: word-address width; store depth is 2^AW words (4·2^AW bytes).
- `LATENCY`, 2: cycles from request sample to `exIns_valid`; legal range ≥1.
- `OOR_DATA`, 32'h0: word returned for out-of-range addresses.

- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `exIns_ren` in 1: fetch request; held high until served.
- `exIns_addr` in 32: byte address relative to external-space base; bits [1:0] ignored.
- `exIns_valid` out 1: response strobe, registered, high exactly one cycle per response.
- `exIns_in` out 32: response word, registered, meaningful while `exIns_valid`=1.
- `busy` out 1: FSM not in IDLE.
- `ld_we` in 1: store write enable.
- `ld_addr` in AW: store word index.
- `ld_data` in 32: store write data.
- `err_oor` out 1: sticky out-of-range flag (only with `EXINS_ERR_EN`).
- `err_addr` out 32: address of first out-of-range request (only with `EXINS_ERR_EN`).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `exIns_ren`=0 → stay. `exIns_ren`=1 → latch `exIns_addr`, load latency counter; go to RESP if `LATENCY`=1, else WAIT.
- WAIT: counter decrements each cycle. `exIns_ren`=0 → abort to IDLE, no response. `exIns_addr` ≠ latched address → re-latch, reload counter, stay in WAIT (restart). Counter expiry → read store at latched index, load `exIns_in`, go to RESP.
- RESP: `exIns_valid`=1 for this single cycle; unconditionally → IDLE. Address and `exIns_ren` are not checked in RESP; the returned word always belongs to the latched address.
- In range: latched `addr[31:AW+2]`==0; word index = `addr[AW+1:2]`. Otherwise respond with `OOR_DATA` (valid still asserted; the fetch stage must never hang).
- The `exIns_addr`=32'hffffffff idle value is ignored because `exIns_ren`=0.
- Load port: write on any cycle with `ld_we`=1; independent of FSM state. Write and response read to the same index in the same cycle → read returns the old word (read-before-write).
- Store contents are not reset; only the FSM and outputs are.

## Timing
- Request first sampled high at edge ending cycle n (address stable) → `exIns_valid`=1 in cycle n+`LATENCY`.
- Address change in cycle m during WAIT → valid in cycle m+`LATENCY`.
- Back-to-back requests (ren held, address advanced after each valid) → one response every `LATENCY`+1 cycles.
- Reset values: `exIns_valid`=0, `exIns_in`=0, `busy`=0, `err_oor`=0, `err_addr`=0, state IDLE. Reset asserted mid-WAIT/RESP → immediate return to IDLE, no response emitted after release until a fresh request is sampled.

## Configuration
- `EXINS_ERR_EN` defined: `err_oor`/`err_addr` ports present; first out-of-range request served (in RESP) sets `err_oor` and captures `err_addr`; later errors do not overwrite; cleared only by reset.
- Undefined: ports absent; out-of-range requests silently return `OOR_DATA`.

## Structure
- Shared package `exins_pkg`: FSM state enum (IDLE/WAIT/RESP), default `OOR_DATA` constant, external-space base constant matching the fetch stage's memory size.
- Sub-module `exins_ram`: 2^AW×32 store with one synchronous read port and one write port, read-before-write.

## Test plan
- `LATENCY`=2, preload mem[3]=32'hDEADBEEF; ren=1, addr=32'hC from cycle 0 → valid=1, exIns_in=32'hDEADBEEF in cycle 2 only; busy high cycles 1–2.
- Addr 32'h0 in cycle 0, changed to 32'h8 in cycle 1 (mem[2]=32'h00500093) → single valid in cycle 3 with 32'h00500093; no response for 32'h0.
- Ren dropped in cycle 1 of WAIT → no valid, busy=0 from cycle 2.
- Ren held, addr 0 then 4 after first valid → valids in cycles 2 and 5 with mem[0], mem[1].
- AW=10, addr 32'h1000 → valid in cycle 2 with 32'h0; with `EXINS_ERR_EN` err_oor=1, err_addr=32'h1000; second OOR at 32'h2000 leaves err_addr=32'h1000.
- `ld_we` to index 5 in the read cycle of a request for 32'h14 → old word returned, new word on the next request; nrst pulsed mid-WAIT → valid stays 0, state IDLE.
